// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the up/down counter slice
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/annotated_register.sv
// rtl/annotated_register.sv - generic register with sync reset value and load enable
module annotated_register #(
    parameter int unsigned        WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Reset wins over load; without load the stored value holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/up_down_counter.sv
// rtl/up_down_counter.sv - up/down counter with registered wrap pulses and zero flag
module up_down_counter
    import counter_pkg::*;
#(
    parameter int unsigned        WIDTH       = 32,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             increment,
    output logic [WIDTH-1:0] count,
    output logic             overflow,
    output logic             underflow,
    output logic             zero
);

    typedef logic [WIDTH-1:0] count_t;

    localparam count_t ALL_ONES = '1;
    localparam count_t ZERO     = '0;
    localparam count_t ONE      = count_t'(1);

    count_t next_count;
    logic   wrap_up;
    logic   wrap_down;

    // Next value is always one step in the selected direction; enable gates the load.
    always_comb begin
        next_count = count;
        wrap_up    = 1'b0;
        wrap_down  = 1'b0;
        if (increment == DIR_UP) begin
            next_count = count + ONE;
            wrap_up    = (count == ALL_ONES);
        end else begin
            next_count = count - ONE;
            wrap_down  = (count == ZERO);
        end
    end

    annotated_register #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_count_reg (
        .clock (clock),
        .reset (reset),
        .load  (enable),
        .d     (next_count),
        .q     (count)
    );

    // Wrap pulses are registered alongside count so they line up with the wrapped value.
    always_ff @(posedge clock) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= enable & wrap_up;
            underflow <= enable & wrap_down;
        end
    end

    assign zero = (count == ZERO);

endmodule

// File: tb/tb_up_down_counter.sv
// tb/tb_up_down_counter.sv - scoreboard bench for up_down_counter at three widths
module tb_up_down_counter;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        increment;

    logic [31:0] count_a;
    logic        ov_a, un_a, zero_a;
    logic [3:0]  count_b;
    logic        ov_b, un_b, zero_b;
    logic [7:0]  count_c;
    logic        ov_c, un_c, zero_c;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0][63:0] cnt;
        logic [2:0]       ov;
        logic [2:0]       un;
        logic [2:0]       zr;
    } exp_t;

    exp_t exp_q[$];

    int              wid [3] = '{32, 4, 8};
    longint unsigned rval[3] = '{0, 0, 5};
    longint unsigned m   [3];
    bit              m_ov[3];
    bit              m_un[3];

    up_down_counter #(.WIDTH(32), .RESET_VALUE(32'd0)) dut_a (
        .clock(clock), .reset(reset), .enable(enable), .increment(increment),
        .count(count_a), .overflow(ov_a), .underflow(un_a), .zero(zero_a)
    );

    up_down_counter #(.WIDTH(4), .RESET_VALUE(4'd0)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .increment(increment),
        .count(count_b), .overflow(ov_b), .underflow(un_b), .zero(zero_b)
    );

    up_down_counter #(.WIDTH(8), .RESET_VALUE(8'd5)) dut_c (
        .clock(clock), .reset(reset), .enable(enable), .increment(increment),
        .count(count_c), .overflow(ov_c), .underflow(un_c), .zero(zero_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int idx,
                       input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, idx, act, exp, $time);
        end
    endtask

    // Reference: modular arithmetic on the count, wrap flags from the pre-step value.
    task automatic step(input bit r, input bit e, input bit i);
        exp_t x;
        longint unsigned modv;
        @(negedge clock);
        reset     = r;
        enable    = e;
        increment = i;
        for (int k = 0; k < 3; k++) begin
            modv = 64'd1 << wid[k];
            if (r) begin
                m[k] = rval[k]; m_ov[k] = 0; m_un[k] = 0;
            end else if (!e) begin
                m_ov[k] = 0; m_un[k] = 0;
            end else if (i) begin
                m_ov[k] = (m[k] == modv - 1);
                m_un[k] = 0;
                m[k]    = (m[k] + 1) % modv;
            end else begin
                m_un[k] = (m[k] == 0);
                m_ov[k] = 0;
                m[k]    = (m[k] + modv - 1) % modv;
            end
            x.cnt[k] = m[k];
            x.ov[k]  = m_ov[k];
            x.un[k]  = m_un[k];
            x.zr[k]  = (m[k] == 0);
        end
        exp_q.push_back(x);
    endtask

    task automatic after_edge();
        @(posedge clock);
        #2;
    endtask

    // Monitor: every edge the counters present a new value; compare against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("count", 0, {32'd0, count_a}, x.cnt[0]);
                chk("overflow", 0, {63'd0, ov_a}, {63'd0, x.ov[0]});
                chk("underflow", 0, {63'd0, un_a}, {63'd0, x.un[0]});
                chk("zero", 0, {63'd0, zero_a}, {63'd0, x.zr[0]});
                chk("count", 1, {60'd0, count_b}, x.cnt[1]);
                chk("overflow", 1, {63'd0, ov_b}, {63'd0, x.ov[1]});
                chk("underflow", 1, {63'd0, un_b}, {63'd0, x.un[1]});
                chk("zero", 1, {63'd0, zero_b}, {63'd0, x.zr[1]});
                chk("count", 2, {56'd0, count_c}, x.cnt[2]);
                chk("overflow", 2, {63'd0, ov_c}, {63'd0, x.ov[2]});
                chk("underflow", 2, {63'd0, un_c}, {63'd0, x.un[2]});
                chk("zero", 2, {63'd0, zero_c}, {63'd0, x.zr[2]});
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b1; increment = 1'b1;

        // Reset hold with enable and increment active.
        repeat (50) step(1, 1, 1);
        after_edge();
        chk("hold_count", 0, {32'd0, count_a}, 0);
        chk("hold_zero", 0, {63'd0, zero_a}, 1);

        // Count up 500.
        repeat (500) step(0, 1, 1);
        after_edge();
        chk("up500", 0, {32'd0, count_a}, 500);
        chk("up500_zero", 0, {63'd0, zero_a}, 0);

        // Count down to 0, then underflow.
        repeat (500) step(0, 1, 0);
        after_edge();
        chk("down0", 0, {32'd0, count_a}, 0);
        chk("down0_zero", 0, {63'd0, zero_a}, 1);
        step(0, 1, 0);
        after_edge();
        chk("under_count", 0, {32'd0, count_a}, 64'hFFFF_FFFF);
        chk("under_pulse", 0, {63'd0, un_a}, 1);
        step(0, 1, 0);
        after_edge();
        chk("under_clear", 0, {63'd0, un_a}, 0);

        // 4-bit overflow after 16 up steps from 0.
        step(1, 0, 0);
        repeat (15) step(0, 1, 1);
        after_edge();
        chk("w4_15", 1, {60'd0, count_b}, 15);
        chk("w4_no_ov", 1, {63'd0, ov_b}, 0);
        step(0, 1, 1);
        after_edge();
        chk("w4_wrap", 1, {60'd0, count_b}, 0);
        chk("w4_ov", 1, {63'd0, ov_b}, 1);

        // Enable gating at 7.
        step(1, 1, 0);
        repeat (7) step(0, 1, 1);
        repeat (10) step(0, 0, 0);
        after_edge();
        chk("gate_hold", 1, {60'd0, count_b}, 7);
        step(0, 1, 1);
        after_edge();
        chk("gate_resume", 1, {60'd0, count_b}, 8);

        // Mid-operation reset to RESET_VALUE=5 at 123, then count down.
        step(1, 0, 1);
        repeat (118) step(0, 1, 1);
        after_edge();
        chk("mid_123", 2, {56'd0, count_c}, 123);
        step(1, 1, 1);
        after_edge();
        chk("mid_reset", 2, {56'd0, count_c}, 5);
        for (int k = 4; k >= 2; k--) begin
            step(0, 1, 0);
            after_edge();
            chk("mid_down", 2, {56'd0, count_c}, longint'(k));
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 2500; n++) begin
            step(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom));
        end

        repeat (3) after_edge();
        chk("queue_drained", 0, longint'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
